// File: rtl/mem_test_engine.sv
// rtl/mem_test_engine.sv - Avalon-MM memory test engine: burst write pass, then burst read-compare pass
module mem_test_engine #(
    parameter int AMM_ADDR_W    = 31,
    parameter int AMM_DATA_W    = 128,
    parameter int AMM_BURST_W   = 11,
    parameter int BYTE_PER_WORD = AMM_DATA_W / 8,
    parameter int ERR_CNT_W     = 16
) (
    input  logic                     clk_ctrl_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [1:0]               cfg_mode_i,
    input  logic [AMM_ADDR_W-1:0]    cfg_start_addr_i,
    input  logic [31:0]              cfg_words_i,
    input  logic [AMM_BURST_W-1:0]   cfg_burst_i,
    input  logic [31:0]              cfg_pattern_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o,
    output logic [ERR_CNT_W-1:0]     err_cnt_o,
    output logic [AMM_ADDR_W-1:0]    err_addr_o,
    output logic [AMM_DATA_W-1:0]    err_data_o,
    output logic [AMM_ADDR_W-1:0]    ctrl_address_o,
    output logic                     ctrl_read_o,
    output logic                     ctrl_write_o,
    output logic [AMM_DATA_W-1:0]    ctrl_writedata_o,
    output logic [AMM_BURST_W-1:0]   ctrl_burstcount_o,
    output logic [BYTE_PER_WORD-1:0] ctrl_byteenable_o,
    input  logic                     ctrl_waitrequest_i,
    input  logic                     ctrl_readdatavalid_i,
    input  logic [AMM_DATA_W-1:0]    ctrl_readdata_i
);

    localparam int REP = AMM_DATA_W / 32;
    localparam logic [AMM_BURST_W-1:0] MAX_BURST = AMM_BURST_W'(2 ** (AMM_BURST_W - 1));
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD_REQ,
        S_RD_DATA,
        S_FIN
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              mode_q, mode_d;
    logic [31:0]             fixed_q, fixed_d;
    logic [31:0]             lfsr_q, lfsr_d;
    logic [31:0]             words_q, words_d;
    logic [31:0]             left_q, left_d;
    logic [AMM_ADDR_W-1:0]   start_addr_q, start_addr_d;
    logic [AMM_ADDR_W-1:0]   base_q, base_d;
    logic [AMM_ADDR_W-1:0]   waddr_q, waddr_d;
    logic [AMM_BURST_W-1:0]  eff_q, eff_d;
    logic [AMM_BURST_W-1:0]  bcnt_q, bcnt_d;
    logic [AMM_BURST_W-1:0]  beats_q, beats_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic [ERR_CNT_W-1:0]    err_cnt_q, err_cnt_d;
    logic [AMM_ADDR_W-1:0]   err_addr_q, err_addr_d;
    logic [AMM_DATA_W-1:0]   err_data_q, err_data_d;

    logic [31:0]             cur_pat;
    logic [AMM_DATA_W-1:0]   exp_word;
    logic [AMM_BURST_W-1:0]  start_eff;
    logic                    beat;
    logic                    req;

    function automatic logic [AMM_BURST_W-1:0] clamp_burst(input logic [AMM_BURST_W-1:0] b);
        if (b == '0) return AMM_BURST_W'(1);
        if (b > MAX_BURST) return MAX_BURST;
        return b;
    endfunction

    // Length of the next burst: full effective burst unless fewer words remain.
    function automatic logic [AMM_BURST_W-1:0] next_len(input logic [31:0] left,
                                                        input logic [AMM_BURST_W-1:0] eff);
        if (left < 32'(eff)) return left[AMM_BURST_W-1:0];
        return eff;
    endfunction

    function automatic logic [31:0] seed_of(input logic [31:0] p);
        return (p == 32'd0) ? 32'd1 : p;
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'd0);
    endfunction

    always_comb begin
        case (mode_q)
            2'd1:    cur_pat = 32'(waddr_q);
            2'd2:    cur_pat = lfsr_q;
            default: cur_pat = fixed_q;
        endcase
    end

    assign exp_word  = {REP{cur_pat}};
    assign start_eff = clamp_burst(cfg_burst_i);
    assign beat      = ((state_q == S_WR) && !ctrl_waitrequest_i) ||
                       ((state_q == S_RD_DATA) && ctrl_readdatavalid_i);

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        fixed_d      = fixed_q;
        lfsr_d       = lfsr_q;
        words_d      = words_q;
        left_d       = left_q;
        start_addr_d = start_addr_q;
        base_d       = base_q;
        waddr_d      = waddr_q;
        eff_d        = eff_q;
        bcnt_d       = bcnt_q;
        beats_d      = beats_q;
        done_d       = 1'b0;
        err_d        = err_q;
        err_cnt_d    = err_cnt_q;
        err_addr_d   = err_addr_q;
        err_data_d   = err_data_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    mode_d       = cfg_mode_i;
                    fixed_d      = cfg_pattern_i;
                    lfsr_d       = seed_of(cfg_pattern_i);
                    words_d      = cfg_words_i;
                    left_d       = cfg_words_i;
                    start_addr_d = cfg_start_addr_i;
                    base_d       = cfg_start_addr_i;
                    waddr_d      = cfg_start_addr_i;
                    eff_d        = start_eff;
                    bcnt_d       = next_len(cfg_words_i, start_eff);
                    beats_d      = next_len(cfg_words_i, start_eff);
                    err_d        = 1'b0;
                    err_cnt_d    = '0;
                    err_addr_d   = '0;
                    err_data_d   = '0;
                    state_d      = (cfg_words_i == 32'd0) ? S_FIN : S_WR;
                end
            end
            S_WR: ;
            S_RD_REQ: begin
                if (!ctrl_waitrequest_i) state_d = S_RD_DATA;
            end
            S_RD_DATA: begin
                if (ctrl_readdatavalid_i && (ctrl_readdata_i != exp_word)) begin
                    if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
                    if (!err_q) begin
                        err_d      = 1'b1;
                        err_addr_d = waddr_q;
                        err_data_d = ctrl_readdata_i;
                    end
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Shared per-word advance for write beats and read beats.
        if (beat) begin
            lfsr_d  = lfsr_next(lfsr_q);
            waddr_d = waddr_q + AMM_ADDR_W'(1);
            left_d  = left_q - 32'd1;
            beats_d = beats_q - AMM_BURST_W'(1);
            if (beats_q == AMM_BURST_W'(1)) begin
                if (left_q == 32'd1) begin
                    if (state_q == S_WR) begin
                        state_d = S_RD_REQ;
                        lfsr_d  = seed_of(fixed_q);
                        waddr_d = start_addr_q;
                        base_d  = start_addr_q;
                        left_d  = words_q;
                        bcnt_d  = next_len(words_q, eff_q);
                        beats_d = next_len(words_q, eff_q);
                    end else begin
                        state_d = S_FIN;
                    end
                end else begin
                    base_d  = base_q + AMM_ADDR_W'(bcnt_q);
                    bcnt_d  = next_len(left_q - 32'd1, eff_q);
                    beats_d = next_len(left_q - 32'd1, eff_q);
                    if (state_q == S_RD_DATA) state_d = S_RD_REQ;
                end
            end
        end
    end

    always_ff @(posedge clk_ctrl_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            mode_q       <= '0;
            fixed_q      <= '0;
            lfsr_q       <= '0;
            words_q      <= '0;
            left_q       <= '0;
            start_addr_q <= '0;
            base_q       <= '0;
            waddr_q      <= '0;
            eff_q        <= '0;
            bcnt_q       <= '0;
            beats_q      <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            err_cnt_q    <= '0;
            err_addr_q   <= '0;
            err_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            fixed_q      <= fixed_d;
            lfsr_q       <= lfsr_d;
            words_q      <= words_d;
            left_q       <= left_d;
            start_addr_q <= start_addr_d;
            base_q       <= base_d;
            waddr_q      <= waddr_d;
            eff_q        <= eff_d;
            bcnt_q       <= bcnt_d;
            beats_q      <= beats_d;
            done_q       <= done_d;
            err_q        <= err_d;
            err_cnt_q    <= err_cnt_d;
            err_addr_q   <= err_addr_d;
            err_data_q   <= err_data_d;
        end
    end

    assign req               = ctrl_write_o || ctrl_read_o;
    assign busy_o            = (state_q == S_WR) || (state_q == S_RD_REQ) || (state_q == S_RD_DATA);
    assign done_o            = done_q;
    assign err_o             = err_q;
    assign err_cnt_o         = err_cnt_q;
    assign err_addr_o        = err_addr_q;
    assign err_data_o        = err_data_q;
    assign ctrl_write_o      = (state_q == S_WR);
    assign ctrl_read_o       = (state_q == S_RD_REQ);
    assign ctrl_address_o    = req ? base_q : '0;
    assign ctrl_burstcount_o = req ? bcnt_q : '0;
    assign ctrl_writedata_o  = ctrl_write_o ? exp_word : '0;
    assign ctrl_byteenable_o = {BYTE_PER_WORD{req}};

endmodule
